// File: rtl/simpleuart_ctrl_pkg.sv
// Shared definitions for the simpleuart TX scheduler slice.
//   state_t    : scheduler FSM states
//   DIV_WR_ALL : byte-enable pattern writing all four divider bytes
//   CFG_ENABLE : value written to the config register to enable the UART
//   GRANT_W    : width of a requester index (supports up to 8 requesters)
package simpleuart_ctrl_pkg;

  localparam int unsigned GRANT_W    = 3;
  localparam logic [3:0]  DIV_WR_ALL = 4'hF;
  localparam logic [31:0] CFG_ENABLE = 32'h1;

  typedef enum logic [2:0] {
    ST_RST,
    ST_INIT_DIV,
    ST_INIT_CFG,
    ST_IDLE,
    ST_SEND,
    ST_DIV
  } state_t;

endpackage

// File: rtl/simpleuart_rr_arb.sv
// Combinational NREQ-way round-robin pick.
//   req    : request vector
//   rr_ptr : index granted last; search starts at rr_ptr+1 and wraps
//   any    : at least one request present
//   winner : first requesting index found in rotated order
module simpleuart_rr_arb
  import simpleuart_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic               any,
  output logic [GRANT_W-1:0] winner
);

  logic [7:0]         req_pad;
  logic [GRANT_W-1:0] cand;

  // Walk from the lowest-priority slot (rr_ptr itself) to the highest
  // (rr_ptr+1), so the last hit written is the round-robin winner.
  always_comb begin
    req_pad = '0;
    req_pad[NREQ-1:0] = req;
    any    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = GRANT_W'((32'(rr_ptr) + NREQ - k) % NREQ);
      if (req_pad[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/simpleuart_tx_sched.sv
// Controller and packet-locked round-robin arbiter in front of the
// simpleuart register port. After reset it writes the baud divider and the
// enable bit, then shares the TX data register among NREQ byte streams.
// A granted requester keeps the UART until it sends a byte flagged last.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   req_valid/data/last per-requester byte stream (byte i at [8i+7:8i])
//   req_ready          byte accepted this cycle
//   cfg_div, cfg_div_load  divider reload request (last pulse wins)
//   uart_div_we/cfg_we/dat_we/wdata  simpleuart register writes
//   uart_dat_wait      simpleuart data register back-pressure
//   busy               scheduler not in IDLE
//   grant_id           current or last granted requester
//   timeout_flag       sticky idle-lock release indicator (optional)
//
// Optional feature: define SIMPLEUART_TX_SCHED_TIMEOUT_EN to release a lock
// whose owner stays idle for TIMEOUT cycles.
module simpleuart_tx_sched
  import simpleuart_ctrl_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter logic [31:0] DIV_DEFAULT = 32'd217
`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT     = 16'd1024
`endif
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [8*NREQ-1:0]  req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic [31:0]        cfg_div,
  input  logic               cfg_div_load,
  output logic [3:0]         uart_div_we,
  output logic               uart_cfg_we,
  output logic               uart_dat_we,
  output logic [31:0]        uart_wdata,
  input  logic               uart_dat_wait,
  output logic               busy,
  output logic [2:0]         grant_id
`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
  ,
  output logic               timeout_flag
`endif
);

  state_t             state, next_state;
  logic [GRANT_W-1:0] rr_ptr;
  logic               div_pend;
  logic [31:0]        div_pend_val;

  logic               arb_any;
  logic [GRANT_W-1:0] arb_winner;
  logic               grant_load;
  logic               rr_load;

  // Requester vectors padded to 8 lanes so a 3-bit grant index always
  // selects a valid lane regardless of NREQ.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  logic [7:0]  ready_pad;
  logic        valid_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    valid_pad = '0;
    last_pad  = '0;
    data_pad  = '0;
    valid_pad[NREQ-1:0]   = req_valid;
    last_pad[NREQ-1:0]    = req_last;
    data_pad[8*NREQ-1:0]  = req_data;
    valid_sel = valid_pad[grant_id];
    byte_sel  = data_pad[{grant_id, 3'b000} +: 8];
  end

  assign req_ready = ready_pad[NREQ-1:0];
  assign busy      = (state != ST_IDLE);

  simpleuart_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .any    (arb_any),
    .winner (arb_winner)
  );

`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        idle_expired;
  assign idle_expired = (state == ST_SEND) && !valid_sel &&
                        (idle_cnt == TIMEOUT - 16'd1);
`endif

  always_comb begin
    next_state  = state;
    uart_div_we = '0;
    uart_cfg_we = 1'b0;
    uart_dat_we = 1'b0;
    uart_wdata  = '0;
    ready_pad   = '0;
    grant_load  = 1'b0;
    rr_load     = 1'b0;
    case (state)
      ST_RST: next_state = ST_INIT_DIV;
      ST_INIT_DIV: begin
        uart_div_we = DIV_WR_ALL;
        uart_wdata  = DIV_DEFAULT;
        next_state  = ST_INIT_CFG;
      end
      ST_INIT_CFG: begin
        uart_cfg_we = 1'b1;
        uart_wdata  = CFG_ENABLE;
        next_state  = ST_IDLE;
      end
      ST_IDLE: begin
        if (div_pend) begin
          next_state = ST_DIV;
        end else if (arb_any) begin
          grant_load = 1'b1;
          next_state = ST_SEND;
        end
      end
      ST_DIV: begin
        uart_div_we = DIV_WR_ALL;
        uart_wdata  = div_pend_val;
        next_state  = ST_IDLE;
      end
      ST_SEND: begin
        uart_dat_we = valid_sel;
        uart_wdata  = {24'h0, byte_sel};
        if (valid_sel && !uart_dat_wait) begin
          ready_pad[grant_id] = 1'b1;
          if (last_pad[grant_id]) begin
            rr_load    = 1'b1;
            next_state = ST_IDLE;
          end
        end
`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
        else if (idle_expired) begin
          rr_load    = 1'b1;
          next_state = ST_IDLE;
        end
`endif
      end
      default: next_state = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_RST;
      rr_ptr       <= GRANT_W'(NREQ - 1);
      grant_id     <= '0;
      div_pend     <= 1'b0;
      div_pend_val <= '0;
    end else begin
      state <= next_state;
      if (grant_load) grant_id <= arb_winner;
      if (rr_load)    rr_ptr   <= grant_id;
      // A new request in the same cycle as the DIV write stays pending.
      if (cfg_div_load) begin
        div_pend     <= 1'b1;
        div_pend_val <= cfg_div;
      end else if (state == ST_DIV) begin
        div_pend <= 1'b0;
      end
    end
  end

`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == ST_SEND && next_state == ST_SEND && !valid_sel)
        idle_cnt <= idle_cnt + 16'd1;
      else
        idle_cnt <= '0;
      if (idle_expired) timeout_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_simpleuart_tx_sched.sv
module tb_simpleuart_tx_sched;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       cfg_div;
  logic              cfg_div_load;
  logic [3:0]        uart_div_we;
  logic              uart_cfg_we;
  logic              uart_dat_we;
  logic [31:0]       uart_wdata;
  logic              uart_dat_wait;
  logic              busy;
  logic [2:0]        grant_id;
`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
  logic              timeout_flag;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simpleuart_tx_sched #(
    .NREQ        (NREQ),
    .DIV_DEFAULT (32'd217)
`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT     (16'd1024)
`endif
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .cfg_div       (cfg_div),
    .cfg_div_load  (cfg_div_load),
    .uart_div_we   (uart_div_we),
    .uart_cfg_we   (uart_cfg_we),
    .uart_dat_we   (uart_dat_we),
    .uart_wdata    (uart_wdata),
    .uart_dat_wait (uart_dat_wait),
    .busy          (busy),
    .grant_id      (grant_id)
`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
    ,
    .timeout_flag  (timeout_flag)
`endif
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with resetn already low for at least one edge;
  // returns at the negedge of the first IDLE cycle.
  task automatic init_seq();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_div_we", 64'(uart_div_we), 64'h0);
    check("rst_cfg_we", 64'(uart_cfg_we), 64'd0);
    check("rst_dat_we", 64'(uart_dat_we), 64'd0);
    check("rst_wdata", 64'(uart_wdata), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_grant", 64'(grant_id), 64'h0);
`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
    check("rst_tflag", 64'(timeout_flag), 64'd0);
`endif
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("init_div_we", 64'(uart_div_we), 64'hF);
    check("init_div_wdata", 64'(uart_wdata), 64'd217);
    check("init_div_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("init_cfg_we", 64'(uart_cfg_we), 64'd1);
    check("init_cfg_wdata", 64'(uart_wdata), 64'h1);
    check("init_cfg_divwe", 64'(uart_div_we), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("init_idle_busy", 64'(busy), 64'd0);
  endtask

  // Random phase state
  logic [8:0] rq [NREQ][$];
  logic [8:0] mq [NREQ][$];
  logic [11:0] expq [$];   // {id[2:0], last, byte}
  bit first [NREQ];

  initial begin
    int ptr, acc_id, cyc, n;
    bit in_pkt, pend_m;
    logic [31:0] pend_val_m;
    logic [11:0] e;
    logic [8:0] b;

    resetn = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    cfg_div = '0; cfg_div_load = 1'b0; uart_dat_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    init_seq();

    // Single byte from req0
    @(posedge clk); #1;
    req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0001;
    @(negedge clk);
    check("single_idle_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_dat_we", 64'(uart_dat_we), 64'd1);
    check("single_wdata", 64'(uart_wdata), 64'h41);
    check("single_ready", 64'(req_ready), 64'h1);
    check("single_grant", 64'(grant_id), 64'd0);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("single_back_idle", 64'(busy), 64'd0);
    check("single_no_we", 64'(uart_dat_we), 64'd0);

    // Back-pressure
    @(posedge clk); #1;
    req_valid = 4'b0001; uart_dat_wait = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      check("bp_dat_we", 64'(uart_dat_we), 64'd1);
      check("bp_wdata", 64'(uart_wdata), 64'h41);
      check("bp_ready", 64'(req_ready), 64'h0);
      @(posedge clk); #1;
    end
    uart_dat_wait = 1'b0;
    @(negedge clk);
    check("bp_release_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("bp_back_idle", 64'(busy), 64'd0);

    // Divider reload deferred to packet end; last request wins
    @(posedge clk); #1;
    req_valid = 4'b0010; req_data[15:8] = 8'hA0; req_last = 4'b0000;
    @(posedge clk); #1;
    cfg_div_load = 1'b1; cfg_div = 32'h55;
    @(negedge clk);
    check("div_pkt_grant", 64'(grant_id), 64'd1);
    check("div_pkt_b0", 64'(uart_wdata), 64'hA0);
    check("div_pkt_r0", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    cfg_div = 32'h1B; req_data[15:8] = 8'hA1; req_last = 4'b0010;
    @(negedge clk);
    check("div_locked_no_div", 64'(uart_div_we), 64'h0);
    check("div_pkt_b1", 64'(uart_wdata), 64'hA1);
    check("div_pkt_r1", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    cfg_div_load = 1'b0;
    req_valid = 4'b0100; req_data[23:16] = 8'hC0; req_last = 4'b0100;
    @(negedge clk);
    check("div_idle_busy", 64'(busy), 64'd0);
    check("div_idle_no_div", 64'(uart_div_we), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("div_write_we", 64'(uart_div_we), 64'hF);
    check("div_write_val", 64'(uart_wdata), 64'h1B);
    check("div_write_no_dat", 64'(uart_dat_we), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("div_then_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("div_next_grant", 64'(grant_id), 64'd2);
    check("div_next_byte", 64'(uart_wdata), 64'hC0);
    check("div_next_ready", 64'(req_ready), 64'h4);
    @(posedge clk); #1 req_valid = '0;

    // Reset in the middle of a stalled packet from req3
    @(posedge clk); #1;
    req_valid = 4'b1000; req_data[31:24] = 8'hD0; req_last = 4'b1000;
    uart_dat_wait = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_grant3", 64'(grant_id), 64'd3);
    check("mid_dat_we", 64'(uart_dat_we), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    req_valid = 4'b1001; req_data[7:0] = 8'hE0; req_last = 4'b1001;
    @(posedge clk); #1;
    uart_dat_wait = 1'b0;
    init_seq();
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_regrant0", 64'(grant_id), 64'd0);
    check("mid_regrant_byte", 64'(uart_wdata), 64'hE0);
    check("mid_regrant_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1 req_valid = '0; req_last = '0;

    // Randomised packets against a round-robin packet-order model
    for (int i = 0; i < NREQ; i++) begin
      int npk;
      npk = $urandom_range(1, 3);
      first[i] = 1'b1;
      for (int p = 0; p < npk; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          b = {(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
          rq[i].push_back(b);
          mq[i].push_back(b);
        end
      end
    end
    ptr = 0;
    forever begin
      int pick;
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (ptr + k) % NREQ;
        if (pick < 0 && mq[j].size() > 0) pick = j;
      end
      if (pick < 0) break;
      do begin
        b = mq[pick].pop_front();
        expq.push_back({3'(pick), b});
      end while (!b[8]);
      ptr = pick;
    end

    in_pkt = 1'b0; pend_m = 1'b0; pend_val_m = '0; cyc = 0;
    while (expq.size() > 0 && cyc < 4000) begin
      cyc++;
      uart_dat_wait = ($urandom_range(0, 3) == 0);
      cfg_div_load = ($urandom_range(0, 19) == 0);
      cfg_div = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        bit gap;
        gap = !first[i] && ($urandom_range(0, 2) == 0);
        req_valid[i] = (rq[i].size() > 0) && !gap;
        req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
        req_last[i] = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
      end
      @(negedge clk);
      check("rnd_accept_rule", 64'(req_ready != '0), 64'(uart_dat_we && !uart_dat_wait));
      if (uart_div_we != 4'h0) begin
        check("rnd_div_outside_pkt", 64'(in_pkt), 64'd0);
        check("rnd_div_pending", 64'(pend_m), 64'd1);
        check("rnd_div_value", 64'(uart_wdata), 64'(pend_val_m));
        pend_m = 1'b0;
      end
      if (req_ready != '0) begin
        acc_id = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) acc_id = i;
        e = expq.pop_front();
        check("rnd_ready_onehot", 64'(req_ready), 64'(1 << acc_id));
        check("rnd_order_id", 64'(acc_id), 64'(e[11:9]));
        check("rnd_byte", 64'(uart_wdata), 64'(e[7:0]));
        b = rq[acc_id].pop_front();
        first[acc_id] = b[8];
        in_pkt = !b[8];
      end
      if (cfg_div_load) begin
        pend_m = 1'b1;
        pend_val_m = cfg_div;
      end
      @(posedge clk); #1;
    end
    check("rnd_all_delivered", 64'(expq.size()), 64'd0);
    req_valid = '0; req_last = '0; cfg_div_load = 1'b0; uart_dat_wait = 1'b0;
    repeat (4) @(posedge clk);
    #1;

`ifdef SIMPLEUART_TX_SCHED_TIMEOUT_EN
    // Owner goes idle mid-packet: lock released after TIMEOUT idle cycles
    req_valid = 4'b0001; req_data[7:0] = 8'h77; req_last = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    check("to_first_ready", 64'(req_ready), 64'h1);
    check("to_flag_clear", 64'(timeout_flag), 64'd0);
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    while (n < 1200) begin
      @(negedge clk);
      n++;
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("to_release_cycle", 64'(n), 64'd1025);
    check("to_flag_set", 64'(timeout_flag), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
